// File: rtl/psu_cnt_if.sv
// ---------------------------------------------------------------------------
// psu_cnt_if
// Opcode hand-off channel between the upstream instruction stage and the
// PSU counter stage.
//
//   opcode_in     opcode offered by upstream (0 = NOP)
//   id_len_in     id length that goes with opcode_in
//   opcode_valid  opcode_in / id_len_in are valid
//   opcode_ready  PSU can take an opcode this cycle
//
// Modports:
//   master  upstream instruction stage (drives opcode, valid)
//   slave   PSU counter stage (drives ready)
// ---------------------------------------------------------------------------
interface psu_cnt_if #(
    parameter int OPCODE_BW = 4,
    parameter int IDLEN_BW  = 4
);
    logic [OPCODE_BW-1:0] opcode_in;
    logic [IDLEN_BW-1:0]  id_len_in;
    logic                 opcode_valid;
    logic                 opcode_ready;

    modport master (
        output opcode_in,
        output id_len_in,
        output opcode_valid,
        input  opcode_ready
    );

    modport slave (
        input  opcode_in,
        input  id_len_in,
        input  opcode_valid,
        output opcode_ready
    );
endinterface

// File: rtl/psu_cnt.sv
// ---------------------------------------------------------------------------
// psu_cnt
// Sequential counter / state-register stage of the PSU. Holds the PSU state,
// the running opcode and the qubit, unit-controller, id and round counters
// that the combinational PSU controller reads, and applies the controller's
// next_* decisions every cycle.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   up (slave)       opcode_in / id_len_in / opcode_valid / opcode_ready
//   next_uc          advance unit-controller step (restarts qubit sweep)
//   next_pch         patch wrap (restarts unit-controller sweep)
//   next_id          advance id
//   next_round       advance round (restarts id)
//   next_opcode      retire the running opcode
//   next_state       next PSU state (0 READY, 1 RUNNING)
//   state            registered PSU state
//   opcode_running   current opcode, NOP (0) when idle
//   qb_counter0      base qubit index
//   uc_counter0      base unit-controller index
//   id_counter       current id
//   id_len           latched id length (never 0)
//   round_counter    current round
//   done             one-cycle pulse after an opcode retires
// ---------------------------------------------------------------------------
module psu_cnt #(
    parameter int OPCODE_BW  = 4,
    parameter int QBADDR_BW  = 8,
    parameter int UCADDR_BW  = 6,
    parameter int IDLEN_BW   = 4,
    parameter int ROUND_BW   = 4,
    parameter int NUM_QBCTRL = 4,
    parameter int NUM_UCC    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    psu_cnt_if.slave             up,
    input  logic                 next_uc,
    input  logic                 next_pch,
    input  logic                 next_id,
    input  logic                 next_round,
    input  logic                 next_opcode,
    input  logic                 next_state,
    output logic                 state,
    output logic [OPCODE_BW-1:0] opcode_running,
    output logic [QBADDR_BW-1:0] qb_counter0,
    output logic [UCADDR_BW-1:0] uc_counter0,
    output logic [IDLEN_BW-1:0]  id_counter,
    output logic [IDLEN_BW-1:0]  id_len,
    output logic [ROUND_BW-1:0]  round_counter,
    output logic                 done
);

    localparam logic [OPCODE_BW-1:0] NOP     = '0;
    localparam logic                 READY   = 1'b0;
    localparam logic                 RUNNING = 1'b1;

    localparam logic [QBADDR_BW-1:0] QB_STEP  = QBADDR_BW'(NUM_QBCTRL);
    localparam logic [UCADDR_BW-1:0] UC_STEP  = UCADDR_BW'(NUM_UCC);
    localparam logic [IDLEN_BW-1:0]  ID_ONE   = IDLEN_BW'(1);
    localparam logic [ROUND_BW-1:0]  RND_ONE  = ROUND_BW'(1);

    logic accept;
    logic retire;
    logic running;

    assign running = (state == RUNNING);

    // A retiring opcode frees the slot in the same cycle, so upstream can
    // hand over the next opcode back-to-back.
    assign up.opcode_ready = (opcode_running == NOP) | next_opcode;
    assign accept          = up.opcode_valid & up.opcode_ready;

    // Controller decisions only count while RUNNING.
    assign retire          = next_opcode & running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= READY;
            opcode_running <= NOP;
            qb_counter0    <= '0;
            uc_counter0    <= '0;
            id_counter     <= '0;
            id_len         <= ID_ONE;
            round_counter  <= '0;
            done           <= 1'b0;
        end else begin
            state <= next_state;
            done  <= retire;

            if (accept) begin
                // A new opcode wins over every counter update, including a
                // retire landing in the same cycle.
                opcode_running <= up.opcode_in;
                // An id length of 0 would make the id loop degenerate.
                id_len         <= (up.id_len_in == '0) ? ID_ONE : up.id_len_in;
                qb_counter0    <= '0;
                uc_counter0    <= '0;
                id_counter     <= '0;
                round_counter  <= '0;
            end else begin
                if (retire) begin
                    opcode_running <= NOP;
                end

                if (running) begin
                    // Qubit sweep advances every cycle; a uc step restarts it.
                    qb_counter0 <= next_uc ? '0 : qb_counter0 + QB_STEP;

                    if (next_pch) begin
                        uc_counter0 <= '0;
                    end else if (next_uc) begin
                        uc_counter0 <= uc_counter0 + UC_STEP;
                    end

                    if (next_round) begin
                        id_counter <= '0;
                    end else if (next_id) begin
                        id_counter <= id_counter + ID_ONE;
                    end

                    if (next_opcode) begin
                        round_counter <= '0;
                    end else if (next_round) begin
                        round_counter <= round_counter + RND_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_psu_cnt.sv
// ---------------------------------------------------------------------------
// tb_psu_cnt
// Self-checking bench for psu_cnt: directed scenarios followed by random
// traffic, all compared against a behavioural model of the counter stage.
// ---------------------------------------------------------------------------
module tb_psu_cnt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       next_uc, next_pch, next_id, next_round, next_opcode, next_state;
    logic       state;
    logic [3:0] opcode_running;
    logic [7:0] qb_counter0;
    logic [5:0] uc_counter0;
    logic [3:0] id_counter;
    logic [3:0] id_len;
    logic [3:0] round_counter;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_state, m_op, m_qb, m_uc, m_id, m_idlen, m_rnd, m_done;

    psu_cnt_if #(.OPCODE_BW(4), .IDLEN_BW(4)) up_if ();

    psu_cnt #(
        .OPCODE_BW (4), .QBADDR_BW (8), .UCADDR_BW (6), .IDLEN_BW (4),
        .ROUND_BW  (4), .NUM_QBCTRL(4), .NUM_UCC   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .up             (up_if.slave),
        .next_uc        (next_uc),
        .next_pch       (next_pch),
        .next_id        (next_id),
        .next_round     (next_round),
        .next_opcode    (next_opcode),
        .next_state     (next_state),
        .state          (state),
        .opcode_running (opcode_running),
        .qb_counter0    (qb_counter0),
        .uc_counter0    (uc_counter0),
        .id_counter     (id_counter),
        .id_len         (id_len),
        .round_counter  (round_counter),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_op = 0; m_qb = 0; m_uc = 0;
        m_id = 0; m_idlen = 1; m_rnd = 0; m_done = 0;
    endfunction

    function automatic int model_ready();
        return ((m_op == 0) || next_opcode) ? 1 : 0;
    endfunction

    // One clock edge as the controller contract describes it, using the
    // inputs currently on the pins.
    function automatic void model_edge();
        bit acc, ret;
        acc = up_if.opcode_valid && (model_ready() == 1);
        ret = next_opcode && (m_state == 1);
        if (acc) begin
            m_op    = up_if.opcode_in;
            m_idlen = (up_if.id_len_in == 0) ? 1 : up_if.id_len_in;
            m_qb = 0; m_uc = 0; m_id = 0; m_rnd = 0;
        end else begin
            if (ret) m_op = 0;
            if (m_state == 1) begin
                m_qb  = next_uc    ? 0 : (m_qb + 4) % 256;
                m_uc  = next_pch   ? 0 : next_uc ? (m_uc + 2) % 64 : m_uc;
                m_id  = next_round ? 0 : next_id ? (m_id + 1) % 16 : m_id;
                m_rnd = next_opcode ? 0 : next_round ? (m_rnd + 1) % 16 : m_rnd;
            end
        end
        m_done  = ret;
        m_state = next_state;
    endfunction

    task automatic check_all();
        check_val("state",  state,          m_state);
        check_val("opcode", opcode_running, m_op);
        check_val("qb",     qb_counter0,    m_qb);
        check_val("uc",     uc_counter0,    m_uc);
        check_val("id",     id_counter,     m_id);
        check_val("id_len", id_len,         m_idlen);
        check_val("round",  round_counter,  m_rnd);
        check_val("done",   done,           m_done);
    endtask

    // Check ready against the current inputs, clock once, check registers.
    task automatic step();
        #1;
        check_val("ready", up_if.opcode_ready, model_ready());
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        up_if.opcode_valid = 1'b0;
        up_if.opcode_in    = 4'd0;
        up_if.id_len_in    = 4'd0;
        next_uc = 0; next_pch = 0; next_id = 0;
        next_round = 0; next_opcode = 0;
    endtask

    task automatic offer(input int op, input int len);
        up_if.opcode_valid = 1'b1;
        up_if.opcode_in    = 4'(op);
        up_if.id_len_in    = 4'(len);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        next_state = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Accept opcode 5 while idle; controller moves to RUNNING.
        offer(5, 3);
        next_state = 1'b1;
        step();
        check_val("acc_op5", opcode_running, 5);
        check_val("acc_len3", id_len, 3);
        idle_inputs();
        #1;
        check_val("busy_ready", up_if.opcode_ready, 0);

        // Qubit sweep advances by NUM_QBCTRL per cycle.
        step(); check_val("qb_4", qb_counter0, 4);
        step(); check_val("qb_8", qb_counter0, 8);
        step(); check_val("qb_12", qb_counter0, 12);
        next_uc = 1;
        step();
        check_val("qb_wrap", qb_counter0, 0);
        check_val("uc_2", uc_counter0, 2);

        // Bring id to 2, then hit every wrap at once.
        next_uc = 0; next_id = 1;
        step(); step();
        check_val("id_2", id_counter, 2);
        next_uc = 1; next_pch = 1; next_id = 1; next_round = 1;
        step();
        check_val("pch_uc0", uc_counter0, 0);
        check_val("round_id0", id_counter, 0);
        check_val("round_1", round_counter, 1);

        // Reach qb=8, round=2, then reset asynchronously mid-count.
        idle_inputs();
        next_round = 1;
        step();
        next_round = 0;
        step();
        check_val("pre_rst_qb", qb_counter0, 8);
        check_val("pre_rst_rnd", round_counter, 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        next_state = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Plain retire.
        offer(5, 3);
        next_state = 1'b1;
        step();
        idle_inputs();
        next_round = 1;
        step(); step();
        next_round = 0;
        next_opcode = 1;
        step();
        check_val("ret_nop", opcode_running, 0);
        check_val("ret_rnd0", round_counter, 0);
        check_val("ret_done", done, 1);
        next_opcode = 0;
        step();
        check_val("ret_done_off", done, 0);

        // Retire and accept in the same cycle; id_len 0 latches as 1.
        offer(3, 9);
        step();
        idle_inputs();
        step(); step();
        next_opcode = 1;
        offer(7, 0);
        step();
        check_val("swap_op7", opcode_running, 7);
        check_val("swap_len1", id_len, 1);
        check_val("swap_qb0", qb_counter0, 0);
        check_val("swap_done", done, 1);
        idle_inputs();
        step();
        check_val("swap_done_off", done, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            up_if.opcode_valid = ($urandom_range(0, 3) == 0);
            up_if.opcode_in    = 4'($urandom_range(0, 15));
            up_if.id_len_in    = 4'($urandom_range(0, 15));
            next_uc     = ($urandom_range(0, 3) == 0);
            next_pch    = ($urandom_range(0, 5) == 0);
            next_id     = ($urandom_range(0, 1) == 0);
            next_round  = ($urandom_range(0, 4) == 0);
            next_opcode = (m_state == 1) && ($urandom_range(0, 9) == 0);
            next_state  = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
